branch_target_buffer: RTL and testbench
=======================================

// Module: branch_target_buffer
// PURPOSE
//  Direct-mapped BTB + 2-bit bimodal predictor in the IF stage, directly upstream of the next-PC mux.
//  Looks up PCF combinationally and drives pred_taken / pred_target, which feed the mux's p / paddr inputs.
//  Trained by resolved conditional branches from EX.
//  Keeps two saturating perf counters: resolved branches and mispredicted directions.
// PARAMETERS
//  INDEX_BITS  6   log2(entries); 64 entries.
//  CNT_W       32  width of perf counters.
// PORTS
//  clk             in   1    core clock; all state updates on rising edge
//  rst_n           in   1    asynchronous, active-low reset
//  pcf             in   32   fetch PC (PCF)
//  pred_taken      out  1    predict taken: hit && ctr[1]
//  pred_target     out  32   stored target on hit, else pcf+4
//  upd_valid       in   1    EX resolved a conditional branch this cycle (BranchTypeE!=0, not flushed)
//  upd_pc          in   32   PC of resolved branch (PCE)
//  upd_taken       in   1    actual outcome (BranchE)
//  upd_target      in   32   actual taken target (BranchTarget)
//  upd_pred_taken  in   1    prediction made for this branch at fetch, carried down the pipe
//  btb_clear       in   1    synchronous invalidate-all (fence.i / context switch)
//  branch_cnt      out  CNT_W  resolved-branch count
//  mispred_cnt     out  CNT_W  direction-mispredict count
// BEHAVIOUR
//  - index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2]; pc[1:0] ignored.
//  - Entry fields: valid(1), tag(32-INDEX_BITS-2), target(32), ctr(2).
//  - Lookup: purely combinational, zero latency.
//    - hit = valid[idx] && tag[idx]==tag(pcf).
//    - Miss: pred_taken=0, pred_target=pcf+4 (mod 2^32).
//  - No read bypass: a lookup in the same cycle as an update to that index sees pre-update contents.
//  - Update (posedge, when upd_valid && !btb_clear):
//    - Tag hit: ctr is 2-bit saturating, +1 if taken else -1; stays at 3/0.
//      If taken, target <= upd_target.
//    - Tag miss, taken: allocate (overwrite); valid=1, tag, target set, ctr=2'b10 (weak taken).
//    - Tag miss, not taken: no change.
//  - btb_clear: next edge clears every valid bit; ctr/tag/target untouched.
//    Clear beats a simultaneous update. Perf counters still count that update.
//  - Perf counters (each saturates at all-ones, never wraps):
//    - branch_cnt += 1 on upd_valid.
//    - mispred_cnt += 1 on upd_valid && (upd_pred_taken != upd_taken).
//  - Reset (async assert, sync deassert handled upstream):
//    - all valid=0, all ctr=2'b01, branch_cnt=0, mispred_cnt=0.
//    - Outputs immediately reflect miss: pred_taken=0, pred_target=pcf+4.
//    - Tag/target arrays are not reset; don't-care while invalid.
//    - Reset mid-update: update lost, no partial entry.
//  - No stall input: pcf held by IF stall gives a stable prediction. Updates come only from EX.
// STRUCTURE
//  - Shared package: CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11;
//    INDEX_BITS default; TAG_W = 30-INDEX_BITS.
//  - One sub-module: sat_ctr2 (next-state function: ctr_in, taken -> ctr_out).
//    Instantiated once on the update path.
//  - Storage: flop arrays, valid[] with async reset; tag/target/ctr arrays.
//    Single write port (upd_pc index), single async read port (pcf index).
// TESTING
//  - Reset: rst_n=0, then pcf=0x100 -> pred_taken=0, pred_target=0x104; both counters 0.
//  - Allocate/predict:
//    - upd pc=0x100, taken=1, target=0x200 -> pcf=0x100 gives pred_taken=1, target=0x200.
//    - Same update with taken=0 on a fresh entry -> still miss.
//  - Hysteresis: from ctr=WT, one not-taken at 0x100 -> ctr=WNT, pred_taken=0.
//    Two takens -> ST; third taken stays ST.
//    Then one not-taken -> WT, still predicts taken.
//  - Aliasing: entry at 0x100, lookup 0x200 (same index at INDEX_BITS=6, tag differs) -> miss.
//    Taken update at 0x200 evicts the 0x100 entry.
//  - Same-cycle hazard and clear:
//    - Update and lookup on 0x100 together -> old prediction that cycle, new one the next.
//    - btb_clear with update -> all miss next cycle.
//  - Counters:
//    - 10 updates, 3 with upd_pred_taken != upd_taken -> branch_cnt=10, mispred_cnt=3.
//    - Preload at all-ones (force) + update -> holds at all-ones.

Source files
------------

// File: rtl/branch_target_buffer_pkg.sv
// Shared types and constants for the branch target buffer: counter encodings and geometry defaults.
package branch_target_buffer_pkg;

  localparam int unsigned BTB_INDEX_BITS = 6;
  localparam int unsigned TAG_W          = 30 - BTB_INDEX_BITS;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_target_buffer_sat_ctr2.sv
// Next-state function of a 2-bit saturating bimodal counter.
module sat_ctr2
  import branch_target_buffer_pkg::*;
(
  input  ctr_e ctr_i,
  input  logic taken_i,
  output ctr_e ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    unique case (ctr_i)
      CTR_SNT: ctr_o = taken_i ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_o = taken_i ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_o = taken_i ? CTR_ST  : CTR_WNT;
      CTR_ST:  ctr_o = taken_i ? CTR_ST  : CTR_WT;
      default: ctr_o = ctr_i;
    endcase
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit bimodal direction counters and saturating perf counters.
// Lookup of the fetch PC is combinational; training comes from resolved branches in EX.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int unsigned INDEX_BITS = BTB_INDEX_BITS,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pcf,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic             btb_clear,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned LTAG_W  = 30 - INDEX_BITS;

  logic [ENTRIES-1:0]      valid_q, valid_d;
  logic [ENTRIES-1:0][1:0] ctr_q, ctr_d;
  logic [LTAG_W-1:0]       tag_q    [ENTRIES];
  logic [31:0]             target_q [ENTRIES];
  logic [CNT_W-1:0]        branch_q, branch_d;
  logic [CNT_W-1:0]        mispred_q, mispred_d;

  logic [INDEX_BITS-1:0]   rd_idx, wr_idx;
  logic [LTAG_W-1:0]       rd_tag, wr_tag;
  logic                    rd_hit, upd_hit;
  logic                    do_upd, alloc, train;
  ctr_e                    ctr_next;
  logic                    unused_upd_pc_bits;

  assign unused_upd_pc_bits = ^upd_pc[1:0];

  // Read port: reads registered contents only, so a same-cycle update is not visible yet.
  assign rd_idx      = pcf[INDEX_BITS+1:2];
  assign rd_tag      = pcf[31:INDEX_BITS+2];
  assign rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign pred_taken  = rd_hit && ctr_q[rd_idx][1];
  assign pred_target = rd_hit ? target_q[rd_idx] : seq_pc(pcf);

  assign wr_idx  = upd_pc[INDEX_BITS+1:2];
  assign wr_tag  = upd_pc[31:INDEX_BITS+2];
  assign upd_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  assign do_upd  = upd_valid && !btb_clear;
  assign alloc   = do_upd && !upd_hit && upd_taken;
  assign train   = do_upd && upd_hit;

  sat_ctr2 u_sat_ctr2 (
    .ctr_i   (ctr_e'(ctr_q[wr_idx])),
    .taken_i (upd_taken),
    .ctr_o   (ctr_next)
  );

  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    if (btb_clear) begin
      valid_d = '0;
    end else if (alloc) begin
      valid_d[wr_idx] = 1'b1;
      ctr_d[wr_idx]   = CTR_WT;
    end else if (train) begin
      ctr_d[wr_idx]   = ctr_next;
    end
  end

  always_comb begin
    branch_d  = branch_q;
    mispred_d = mispred_q;
    if (upd_valid && !(&branch_q)) begin
      branch_d = branch_q + CNT_W'(1);
    end
    if (upd_valid && (upd_pred_taken != upd_taken) && !(&mispred_q)) begin
      mispred_d = mispred_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      ctr_q     <= {ENTRIES{CTR_WNT}};
      branch_q  <= '0;
      mispred_q <= '0;
    end else begin
      valid_q   <= valid_d;
      ctr_q     <= ctr_d;
      branch_q  <= branch_d;
      mispred_q <= mispred_d;
    end
  end

  // Tag/target carry no reset; they are only meaningful behind a set valid bit.
  always_ff @(posedge clk) begin
    if (alloc || (train && upd_taken)) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= upd_target;
    end
  end

  assign branch_cnt  = branch_q;
  assign mispred_cnt = mispred_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: driver pushes model predictions, monitor compares at negedge.
module tb_branch_target_buffer;

  localparam int unsigned IB      = 6;
  localparam int unsigned CW      = 8;
  localparam int unsigned ENT     = 64;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   pcf = '0;
  logic          pred_taken;
  logic [31:0]   pred_target;
  logic          upd_valid = 1'b0;
  logic [31:0]   upd_pc = '0;
  logic          upd_taken = 1'b0;
  logic [31:0]   upd_target = '0;
  logic          upd_pred_taken = 1'b0;
  logic          btb_clear = 1'b0;
  logic [CW-1:0] branch_cnt;
  logic [CW-1:0] mispred_cnt;

  branch_target_buffer #(.INDEX_BITS(IB), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pcf            (pcf),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .btb_clear      (btb_clear),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays indexed by (pc/4) mod entries, tag = pc / (4*entries).
  bit          m_valid  [ENT];
  int unsigned m_tag    [ENT];
  logic [31:0] m_target [ENT];
  int          m_ctr    [ENT];
  int unsigned m_bc, m_mc;

  typedef struct {
    string       nm;
    logic        pt;
    logic [31:0] tgt;
    int unsigned bc;
    int unsigned mc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   done = 1'b0;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % ENT;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * ENT);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endfunction

  function automatic void model_update(input bit uv, input logic [31:0] pc, input bit tk,
                                       input logic [31:0] tgt, input bit upt, input bit clr);
    int unsigned i;
    i = idx_of(pc);
    if (uv) begin
      if (m_bc < CNT_MAX) m_bc++;
      if (upt != tk && m_mc < CNT_MAX) m_mc++;
    end
    if (clr) begin
      for (int k = 0; k < ENT; k++) m_valid[k] = 1'b0;
    end else if (uv) begin
      if (m_hit(pc)) begin
        m_ctr[i] = tk ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1) : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
        if (tk) m_target[i] = tgt;
      end else if (tk) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(pc);
        m_target[i] = tgt;
        m_ctr[i]    = 2;
      end
    end
  endfunction

  task automatic step(input bit rst, input bit uv, input logic [31:0] upc, input bit tk,
                      input logic [31:0] utgt, input bit upt, input bit clr,
                      input logic [31:0] lpc, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n          = rst;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_taken      = tk;
    upd_target     = utgt;
    upd_pred_taken = upt;
    btb_clear      = clr;
    pcf            = lpc;
    if (!rst) model_reset();
    e.nm  = nm;
    e.pt  = m_hit(lpc) && (m_ctr[idx_of(lpc)] >= 2);
    e.tgt = m_hit(lpc) ? m_target[idx_of(lpc)] : lpc + 32'd4;
    e.bc  = m_bc;
    e.mc  = m_mc;
    exp_q.push_back(e);
    if (rst) model_update(uv, upc, tk, utgt, upt, clr);
  endtask

  task automatic look(input logic [31:0] lpc, input string nm);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, lpc, nm);
  endtask

  task automatic upd(input logic [31:0] upc, input bit tk, input logic [31:0] utgt,
                     input bit upt, input logic [31:0] lpc, input string nm);
    step(1'b1, 1'b1, upc, tk, utgt, upt, 1'b0, lpc, nm);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
    if ($urandom_range(0, 15) == 0) p = $urandom;
    return p;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  // Monitor: one expected record per driven cycle, compared mid-cycle.
  initial begin
    exp_t e;
    while (!(done && exp_q.size() == 0)) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cmp({e.nm, ".pred_taken"},  {31'b0, pred_taken}, {31'b0, e.pt});
        cmp({e.nm, ".pred_target"}, pred_target, e.tgt);
        cmp({e.nm, ".branch_cnt"},  32'(branch_cnt), e.bc);
        cmp({e.nm, ".mispred_cnt"}, 32'(mispred_cnt), e.mc);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Driver
  initial begin
    model_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100, "reset");
    look(32'h100, "post_reset");
    upd(32'h100, 1'b0, 32'h200, 1'b0, 32'h100, "nt_fresh");
    look(32'h100, "nt_no_alloc");
    upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h100, "alloc_same_cycle");
    look(32'h100, "alloc_predict");
    upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h100, "hazard_old");
    look(32'h100, "hyst_wnt");
    upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h100, "tk1");
    upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h100, "tk2");
    upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h100, "tk3_st");
    upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h100, "nt_from_st");
    look(32'h100, "wt_still_taken");
    look(32'h200, "alias_miss");
    upd(32'h200, 1'b1, 32'h300, 1'b0, 32'h200, "alias_alloc");
    look(32'h100, "evicted");
    look(32'h200, "alias_hit");
    step(1'b1, 1'b1, 32'h300, 1'b1, 32'h400, 1'b0, 1'b1, 32'h200, "clear_with_upd");
    look(32'h200, "cleared_a");
    look(32'h300, "cleared_b");
    upd(32'h100, 1'b1, 32'h240, 1'b1, 32'h100, "realloc");
    step(1'b0, 1'b1, 32'h104, 1'b1, 32'h500, 1'b0, 1'b0, 32'h100, "reset_mid");
    look(32'h104, "reset_mid_lost");
    for (int i = 0; i < 10; i++) begin
      upd(32'h100 + 32'(4 * i), i[0], 32'h800 + 32'(i), ((i == 2) || (i == 5) || (i == 7)) ? !i[0] : i[0],
          32'h100, "cnt_seq");
    end
    look(32'h100, "cnt_10_3");
    for (int n = 0; n < 800; n++) begin
      step(1'b1, $urandom_range(0, 9) != 0, rand_pc(), 1'($urandom), $urandom & 32'hFFFF_FFFC,
           1'($urandom), $urandom_range(0, 39) == 0, rand_pc(), "rand");
    end
    look(32'h100, "final");
    @(posedge clk);
    #1;
    done = 1'b1;
  end

endmodule
